// File: rtl/y86_writeback_regfile.sv
// y86_writeback_regfile: write side of the Y86-64 SEQ register file.
// Owns the 15 x 64-bit architectural registers, decodes dstE/dstM from the
// committing instruction and writes valE/valM at the rising edge.
// A sticky RUN/HALT state blocks every write after a non-AOK status.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retired_cnt output.
//
// Handshake: instr_valid is a one-cycle qualifier with no ready; when it is
// high at a rising edge the instruction is retired (or halts the machine),
// when low the edge has no architectural effect.
module y86_writeback_regfile #(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
    parameter int          CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [2:0]  stat,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] rax,
    output logic [63:0] rcx,
    output logic [63:0] rdx,
    output logic [63:0] rbx,
    output logic [63:0] rsp,
    output logic [63:0] rbp,
    output logic [63:0] rsi,
    output logic [63:0] rdi,
    output logic [63:0] r8,
    output logic [63:0] r9,
    output logic [63:0] r10,
    output logic [63:0] r11,
    output logic [63:0] r12,
    output logic [63:0] r13,
    output logic [63:0] r14,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic        halted
`ifdef WB_RETIRE_CNT_EN
   ,output logic [CNT_W-1:0] retired_cnt
`endif
);

    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] R_RSP    = 4'h4;
    localparam logic [2:0] STAT_AOK = 3'd1;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // CNT_W must be at least 1; a zero-width counter is meaningless.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    // halted mirrors the state register, so the FSM state is always visible.
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
    state_t state;

    logic [63:0] regs [15];
    logic        commit;
    logic        halt_req;

    assign commit   = instr_valid && (state == RUN) && (stat == STAT_AOK);
    assign halt_req = instr_valid && (state == RUN) && (stat != STAT_AOK);

    // Destination decode from icode; only a taken cmov writes its rB.
    always_comb begin
        dstE = R_NONE;
        dstM = R_NONE;
        case (icode)
            I_CMOVXX: dstE = cnd ? rB : R_NONE;
            I_IRMOVQ: dstE = rB;
            I_OPQ:    dstE = rB;
            I_MRMOVQ: dstM = rA;
            I_CALL:   dstE = R_RSP;
            I_RET:    dstE = R_RSP;
            I_PUSHQ:  dstE = R_RSP;
            I_POPQ: begin
                dstE = R_RSP;
                dstM = rA;
            end
            default: begin
                dstE = R_NONE;
                dstM = R_NONE;
            end
        endcase
    end

    // RUN/HALT state: the first committing non-AOK status parks the machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
        end
    end

    // Register file write; M port takes priority when both target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? STACK_INIT : 64'h0;
            end
        end else if (commit) begin
            for (int i = 0; i < 15; i++) begin
                if (dstM == 4'(i)) begin
                    regs[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Retire counter counts every committed instruction, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (commit) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end
`endif

    assign rax = regs[0];
    assign rcx = regs[1];
    assign rdx = regs[2];
    assign rbx = regs[3];
    assign rsp = regs[4];
    assign rbp = regs[5];
    assign rsi = regs[6];
    assign rdi = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Bench for y86_writeback_regfile: vector table plus hand-written reset,
// halt and retire-counter sequences, checked against a register model.
module tb_y86_writeback_regfile;

`ifdef WB_RETIRE_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif
    localparam logic [3:0] F = 4'hF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        instr_valid;
    logic [3:0]  icode, ra, rb;
    logic        cnd;
    logic [2:0]  stat;
    logic [63:0] vale, valm;
    logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
    logic [63:0] r8, r9, r10, r11, r12, r13, r14;
    logic [3:0]  dst_e, dst_m;
    logic        halted;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    y86_writeback_regfile #(
        .STACK_INIT (64'h0000_0000_0000_0200),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .icode       (icode),
        .rA          (ra),
        .rB          (rb),
        .cnd         (cnd),
        .stat        (stat),
        .valE        (vale),
        .valM        (valm),
        .rax (rax), .rcx (rcx), .rdx (rdx), .rbx (rbx),
        .rsp (rsp), .rbp (rbp), .rsi (rsi), .rdi (rdi),
        .r8  (r8),  .r9  (r9),  .r10 (r10), .r11 (r11),
        .r12 (r12), .r13 (r13), .r14 (r14),
        .dstE        (dst_e),
        .dstM        (dst_m),
        .halted      (halted)
`ifdef WB_RETIRE_CNT_EN
       ,.retired_cnt (retired_cnt)
`endif
    );

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [2:0]  stat;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  exp_e;
        logic [3:0]  exp_m;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic valid, logic [3:0] ic, logic [3:0] a,
                                logic [3:0] b, logic c, logic [2:0] st, logic [63:0] e,
                                logic [63:0] m, logic [3:0] xe, logic [3:0] xm);
        vec_t v;
        v.name = name; v.valid = valid; v.icode = ic; v.ra = a; v.rb = b;
        v.cnd = c; v.stat = st; v.vale = e; v.valm = m; v.exp_e = xe; v.exp_m = xm;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] model [15];
    logic        model_halted;
    logic [CNT_W-1:0] model_cnt;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] get_reg(int i);
        case (i)
            0: return rax;   1: return rcx;   2: return rdx;   3: return rbx;
            4: return rsp;   5: return rbp;   6: return rsi;   7: return rdi;
            8: return r8;    9: return r9;    10: return r10;  11: return r11;
            12: return r12;  13: return r13;  default: return r14;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        model[4]     = 64'h200;
        model_halted = 1'b0;
        model_cnt    = '0;
    endtask

    // Expected snapshot: 15 registers, then halted, then the retire count.
    task automatic push_expected();
        for (int i = 0; i < 15; i++) exp_q.push_back(model[i]);
        exp_q.push_back({63'h0, model_halted});
        exp_q.push_back(64'(model_cnt));
    endtask

    task automatic check_state(string tag);
        logic [63:0] exp;
        for (int i = 0; i < 15; i++) begin
            exp = exp_q.pop_front();
            check($sformatf("%s r%0d", tag, i), get_reg(i), exp);
        end
        exp = exp_q.pop_front();
        check($sformatf("%s halted", tag), {63'h0, halted}, exp);
        exp = exp_q.pop_front();
`ifdef WB_RETIRE_CNT_EN
        check($sformatf("%s retired_cnt", tag), 64'(retired_cnt), exp);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(vec_t v);
        @(negedge clk);
        instr_valid = v.valid; icode = v.icode; ra = v.ra; rb = v.rb;
        cnd = v.cnd; stat = v.stat; vale = v.vale; valm = v.valm;
        #1;
        check({v.name, " dstE"}, {60'h0, dst_e}, {60'h0, v.exp_e});
        check({v.name, " dstM"}, {60'h0, dst_m}, {60'h0, v.exp_m});
        if (v.valid && !model_halted) begin
            if (v.stat == 3'd1) begin
                if (v.exp_e != F) model[v.exp_e] = v.vale;
                if (v.exp_m != F) model[v.exp_m] = v.valm;
                model_cnt = model_cnt + 1'b1;
            end else begin
                model_halted = 1'b1;
            end
        end
        push_expected();
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check_state(v.name);
    endtask

    // Reset asserted in the middle of the high phase, checked before any edge.
    task automatic mid_cycle_reset(string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_expected();
        check_state({tag, " during reset"});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_expected();
        check_state({tag, " after idle"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; icode = 4'h1; ra = F; rb = F;
        cnd = 1'b0; stat = 3'd1; vale = '0; valm = '0;
        model_reset();
        #12;
        push_expected();
        check_state("power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        //              name            v  ic    rA    rB    c  st  valE        valM       dE    dM
        vecs.push_back(mk("irmovq rdx", 1, 4'h3, F,    4'h2, 0, 1, 64'h1234,   64'h0,     4'h2, F));
        vecs.push_back(mk("cmov nt",    1, 4'h2, 4'h0, 4'h1, 0, 1, 64'h55,     64'h0,     F,    F));
        vecs.push_back(mk("cmov t",     1, 4'h2, 4'h0, 4'h1, 1, 1, 64'h55,     64'h0,     4'h1, F));
        vecs.push_back(mk("cmov t rbF", 1, 4'h2, 4'h0, F,    1, 1, 64'h66,     64'h0,     F,    F));
        vecs.push_back(mk("popq rsp",   1, 4'hB, 4'h4, F,    0, 1, 64'h208,    64'hAA,    4'h4, 4'h4));
        vecs.push_back(mk("popq rbx",   1, 4'hB, 4'h3, F,    0, 1, 64'h208,    64'hAA,    4'h4, 4'h3));
        vecs.push_back(mk("opq rbp",    1, 4'h6, 4'h2, 4'h5, 0, 1, 64'hDEAD,   64'h0,     4'h5, F));
        vecs.push_back(mk("mrmovq rsi", 1, 4'h5, 4'h6, 4'h2, 0, 1, 64'h77,     64'hBEEF,  F,    4'h6));
        vecs.push_back(mk("call",       1, 4'h8, F,    F,    0, 1, 64'h1F8,    64'h0,     4'h4, F));
        vecs.push_back(mk("ret",        1, 4'h9, F,    F,    0, 1, 64'h200,    64'h99,    4'h4, F));
        vecs.push_back(mk("pushq",      1, 4'hA, 4'h1, F,    0, 1, 64'h1F0,    64'h0,     4'h4, F));
        vecs.push_back(mk("nop",        1, 4'h1, 4'h2, 4'h3, 1, 1, 64'h11,     64'h22,    F,    F));
        vecs.push_back(mk("rmmovq",     1, 4'h4, 4'h2, 4'h3, 1, 1, 64'h33,     64'h44,    F,    F));
        vecs.push_back(mk("jxx",        1, 4'h7, F,    F,    1, 1, 64'h55,     64'h66,    F,    F));
        vecs.push_back(mk("icode C",    1, 4'hC, 4'h1, 4'h2, 1, 1, 64'h1,      64'h2,     F,    F));
        vecs.push_back(mk("icode F",    1, 4'hF, 4'h1, 4'h2, 1, 1, 64'h1,      64'h2,     F,    F));
        vecs.push_back(mk("invalid",    0, 4'h3, F,    4'h7, 0, 1, 64'h999,    64'h0,     4'h7, F));
        vecs.push_back(mk("invalid hlt",0, 4'h0, F,    F,    0, 2, 64'h0,      64'h0,     F,    F));
        vecs.push_back(mk("irmovq r14", 1, 4'h3, F,    4'hE, 0, 1, 64'hFFFF_0000_1234_5678, 64'h0, 4'hE, F));
        foreach (vecs[k]) step(vecs[k]);

        for (int k = 0; k < 20; k++) begin
            logic [3:0]  b;
            logic [3:0]  ic;
            logic [63:0] e;
            b  = 4'($urandom_range(0, 14));
            ic = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'h6;
            e  = {$urandom, $urandom};
            step(mk($sformatf("rand%0d", k), 1, ic, 4'($urandom_range(0, 15)), b, 0, 1, e,
                    {$urandom, $urandom}, b, F));
        end

        mid_cycle_reset("reset1");

        step(mk("halt hlt",     1, 4'h0, F, F,    0, 2, 64'h0, 64'h0, F,    F));
        step(mk("halted irmov", 1, 4'h3, F, 4'h0, 0, 1, 64'h7, 64'h0, 4'h0, F));
        step(mk("halted popq",  1, 4'hB, 4'h3, F, 0, 1, 64'h8, 64'h9, 4'h4, 4'h3));
        mid_cycle_reset("reset2");
        step(mk("run irmov",    1, 4'h3, F, 4'h0, 0, 1, 64'h7, 64'h0, 4'h0, F));
        step(mk("adr irmov",    1, 4'h3, F, 4'h1, 0, 3, 64'h99, 64'h0, 4'h1, F));
        step(mk("after adr",    1, 4'h3, F, 4'h2, 0, 1, 64'h98, 64'h0, 4'h2, F));
        mid_cycle_reset("reset3");
        step(mk("ins halt",     1, 4'h6, 4'h1, 4'h2, 0, 4, 64'h5, 64'h0, 4'h2, F));
        mid_cycle_reset("reset4");

`ifdef WB_RETIRE_CNT_EN
        for (int k = 0; k < 4; k++)
            step(mk("cnt irmovq", 1, 4'h3, F, 4'(k), 0, 1, 64'(k + 1), 64'h0, 4'(k), F));
        step(mk("cnt nop",   1, 4'h1, F, F, 0, 1, 64'h0, 64'h0, F, F));
        step(mk("cnt idle0", 0, 4'h3, F, 4'h5, 0, 1, 64'h1, 64'h0, 4'h5, F));
        step(mk("cnt idle1", 0, 4'h1, F, F,    0, 1, 64'h1, 64'h0, F,    F));
        check("retired five", 64'(retired_cnt), 64'd5);
        for (int k = 0; k < 11; k++)
            step(mk("cnt fill", 1, 4'h1, F, F, 0, 1, 64'h0, 64'h0, F, F));
        check("retired wrap", 64'(retired_cnt), 64'd0);
        step(mk("cnt halt",   1, 4'h0, F, F, 0, 2, 64'h0, 64'h0, F, F));
        step(mk("cnt frozen", 1, 4'h1, F, F, 0, 1, 64'h0, 64'h0, F, F));
        check("retired frozen", 64'(retired_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
